ntt_sequencer: RTL and testbench
================================

# ntt_sequencer

Address and control sequencer placed directly upstream of the `butterfly` datapath in the NTT core. It runs all log2(N) stages of a forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT over a coefficient RAM:
- issues one butterfly pair per cycle, with read addresses, twiddle ROM index and `sel_butterfly`;
- delays the pair addresses to produce aligned write-back strobes;
- drains the pipeline between stages so that no stage reads a coefficient before it has been written back.

## Interface
- `N_LOG2`, default 8: log2 of the polynomial length. N = 256, 8 stages, 128 butterflies per stage.
- `PIPE_DEPTH`, default 2: cycles from read issue to write-back. This is the RAM/ROM sync-read latency plus the butterfly register stages. Must be ≥ 1.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  begin a transform; accepted only when idle.
- `inverse_i`  in  1  0 = forward, 1 = inverse; sampled when `start_i` is accepted.
- `busy_o`  out  1  transform in progress.
- `done_o`  out  1  one-cycle pulse when the transform completes.
- `rd_en_o`  out  1  read strobe for the coefficient RAM and the twiddle ROM.
- `rd_addr_a_o`, `rd_addr_b_o`  out  N_LOG2  read addresses of the butterfly pair.
- `twiddle_idx_o`  out  N_LOG2  twiddle ROM index, aligned with the read addresses.
- `sel_butterfly_o`  out  1  latched `inverse_i`, held for the whole transform.
- `wr_en_o`  out  1  write strobe.
- `wr_addr_a_o`, `wr_addr_b_o`  out  N_LOG2  write-back addresses.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE → RUN when `start_i`=1.
  - RUN → DRAIN after issuing butterfly 2^(N_LOG2-1)-1 of the current stage.
  - DRAIN lasts PIPE_DEPTH cycles, then goes → RUN with stage+1, or → IDLE if the stage was the last.
- **Counters:** stage s in 0..N_LOG2-1; butterfly counter bf in 0..2^(N_LOG2-1)-1. Both clear to 0 on acceptance of `start_i`.
- **Forward addressing** (half-length = 2^(N_LOG2-1-s)):
  - `rd_addr_a_o` = bf with a 0 bit inserted at position N_LOG2-1-s; `rd_addr_b_o` = the same with a 1 bit.
  - Group g = bf >> (N_LOG2-1-s); twiddle index = 2^s + g.
- **Inverse addressing** (half-length = 2^s):
  - The 0/1 bit is inserted at position s.
  - Group g = bf >> s; twiddle index = 2^(N_LOG2-s) - 1 - g.
  - Twiddle negation is done by the butterfly via `sel_butterfly`.
- **Outputs in RUN:** `rd_en_o`=1 on every RUN cycle, never in IDLE or DRAIN.
- **Write-back path:** {`rd_en_o`, `rd_addr_a_o`, `rd_addr_b_o`} go through a PIPE_DEPTH-deep delay line, which drives `wr_en_o`/`wr_addr_*`.
- **Coverage per stage:** every address 0..N-1 appears exactly once as either the a or the b address.
- **Start while busy:** `start_i` in RUN or DRAIN is ignored; `inverse_i` changes while busy have no effect.
- **Reset mid-operation:**
  - All outputs go to 0 immediately, the delay line is flushed and the FSM goes to IDLE.
  - No `wr_en_o` is asserted after release until a new transform starts.

## Timing
- **Reset values:** every output is 0, including `sel_butterfly_o`. State IDLE, counters 0.
- **Issue timing:** `start_i` accepted at edge t. From t+1, `busy_o`=1 and the first pair is issued; one pair per cycle, no bubbles within a stage.
- **Write alignment:** `wr_en_o` goes high exactly PIPE_DEPTH cycles after the corresponding `rd_en_o`, with identical addresses.
- **Stage gap:** PIPE_DEPTH cycles with `rd_en_o`=0. The last write of stage s coincides with the last DRAIN cycle, so no read-after-write hazard is possible.
- **Transform length:** `busy_o` is high for N_LOG2·(2^(N_LOG2-1)+PIPE_DEPTH) cycles; default 8·130 = 1040.
- **Completion:**
  - `done_o` pulses in the first IDLE cycle after the final DRAIN, with `busy_o`=0.
  - A `start_i` in that same cycle is accepted.

## Structure
- **Shared package `ntt_pkg`:**
  - `N_LOG2` default constant;
  - modulus `Q` = 8380417;
  - state enum `ntt_seq_state_t` {IDLE, RUN, DRAIN};
  - address typedef `ntt_addr_t` = logic [N_LOG2-1:0].
- **Sub-module `ntt_wb_delay`:** parameterised PIPE_DEPTH shift register of {valid, addr_a, addr_b}, async-reset to 0. It is reused by the top-level NTT core for other aligned side-band signals.

## Test plan
- **Forward, default params:**
  - t+1: a/b = 0/128, twiddle 1; next cycle 1/129, twiddle 1.
  - Last pair of stage 0: 127/255, then 2 cycles with `rd_en_o`=0.
  - Stage 1: bf0 → 0/64, twiddle 2; bf64 → 128/192, twiddle 3.
- **Forward stage 7:** bf0 → 0/1, twiddle 128; bf127 → 254/255, twiddle 255.
- **Inverse, `inverse_i`=1:**
  - Stage 0: bf0 → 0/1, twiddle 255; bf1 → 2/3, twiddle 254.
  - Stage 7: bf0 → 0/128, twiddle 1. `sel_butterfly_o`=1 throughout.
- **Alignment and length:**
  - Every `wr_en_o` occurs 2 cycles after its `rd_en_o`, with matching addresses; 1024 writes total.
  - `busy_o` high for 1040 cycles; exactly one `done_o` pulse.
- **Start handling:**
  - `start_i` held high during RUN/DRAIN → no restart, counters undisturbed.
  - `start_i` in the `done_o` cycle → new transform begins the next cycle.
- **Reset mid-stage 3:** all outputs read 0 in the same cycle; no `wr_en_o` after release; a fresh `start_i` resumes normal stage-0 sequencing.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT core: default transform size, modulus,
// sequencer state encoding and the coefficient address type.
package ntt_pkg;

    // Default log2 of the polynomial length (N = 256).
    localparam int NTT_N_LOG2 = 8;

    // Coefficient modulus.
    localparam int unsigned Q = 32'd8380417;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ntt_seq_state_t;

    typedef logic [NTT_N_LOG2-1:0] ntt_addr_t;

endpackage : ntt_pkg

// File: rtl/ntt_wb_delay.sv
// Fixed-latency shift register for {valid, addr_a, addr_b}. Used to line up
// write-back strobes with the butterfly output; also reused by the NTT core
// for other side-band signals that must follow the datapath latency.
//
// Ports:
//   clk, rst                      clock, async active-high reset (flushes to 0)
//   src_valid/src_addr_a/_b       values entering the line
//   dly_valid/dly_addr_a/_b       the same values DEPTH cycles later
module ntt_wb_delay #(
    parameter int DEPTH = 2,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_valid,
    input  logic [AW-1:0] src_addr_a,
    input  logic [AW-1:0] src_addr_b,
    output logic          dly_valid,
    output logic [AW-1:0] dly_addr_a,
    output logic [AW-1:0] dly_addr_b
);

    logic [DEPTH-1:0] vld_sr;
    logic [AW-1:0]    a_sr [DEPTH];
    logic [AW-1:0]    b_sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= src_valid;
            a_sr[0]   <= src_addr_a;
            b_sr[0]   <= src_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                a_sr[i]   <= a_sr[i-1];
                b_sr[i]   <= b_sr[i-1];
            end
        end
    end

    assign dly_valid  = vld_sr[DEPTH-1];
    assign dly_addr_a = a_sr[DEPTH-1];
    assign dly_addr_b = b_sr[DEPTH-1];

endmodule : ntt_wb_delay

// File: rtl/ntt_sequencer.sv
// Address/control sequencer feeding the butterfly datapath. Runs all N_LOG2
// stages of a forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT,
// issuing one butterfly pair per cycle, and drains the pipeline between
// stages so no stage reads a coefficient before it has been written back.
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   start_i, inverse_i        start request (idle only), direction sampled at start
//   busy_o, done_o            transform in progress, one-cycle completion pulse
//   rd_en_o, rd_addr_a/b_o    coefficient RAM / twiddle ROM read strobe and pair
//   twiddle_idx_o             twiddle ROM index aligned with the read pair
//   sel_butterfly_o           latched direction for the butterfly
//   wr_en_o, wr_addr_a/b_o    write-back strobe and pair, PIPE_DEPTH after read
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i; all strobes low
// RUN   | issuing butterfly bf of the current stage, one per cycle
// DRAIN | PIPE_DEPTH empty cycles so the stage's writes land first
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int N_LOG2     = NTT_N_LOG2,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              inverse_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [N_LOG2-1:0] rd_addr_a_o,
    output logic [N_LOG2-1:0] rd_addr_b_o,
    output logic [N_LOG2-1:0] twiddle_idx_o,
    output logic              sel_butterfly_o,
    output logic              wr_en_o,
    output logic [N_LOG2-1:0] wr_addr_a_o,
    output logic [N_LOG2-1:0] wr_addr_b_o
);

    localparam int BW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    typedef logic [N_LOG2-1:0] addr_t;
    typedef logic [N_LOG2:0]   wide_t;

    localparam logic [BW-1:0] BF_LAST    = '1;
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DEPTH - 1);

    ntt_seq_state_t state_q, state_n;
    logic [BW-1:0]  bf_q, bf_n;
    logic [SW-1:0]  stage_q, stage_n;
    logic [DW-1:0]  dcnt_q, dcnt_n;
    logic           inv_q, inv_n;
    logic           done_q, done_n;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bf_q    <= '0;
            stage_q <= '0;
            dcnt_q  <= '0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            bf_q    <= bf_n;
            stage_q <= stage_n;
            dcnt_q  <= dcnt_n;
            inv_q   <= inv_n;
            done_q  <= done_n;
        end
    end

    // ---------------- next-state ----------------
    always_comb begin
        state_n = state_q;
        bf_n    = bf_q;
        stage_n = stage_q;
        dcnt_n  = dcnt_q;
        inv_n   = inv_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_n = RUN;
                    bf_n    = '0;
                    stage_n = '0;
                    inv_n   = inverse_i;
                end
            end
            RUN: begin
                if (bf_q == BF_LAST) begin
                    state_n = DRAIN;
                    bf_n    = '0;
                    dcnt_n  = DRAIN_LOAD;
                end else begin
                    bf_n = bf_q + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == '0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_n = IDLE;
                        stage_n = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                        stage_n = stage_q + 1'b1;
                    end
                end else begin
                    dcnt_n = dcnt_q - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ---------------- pair addressing ----------------
    // The pair bit is inserted at position pos into bf: bits of bf below pos
    // stay in place, bits at/above pos move up by one. Forward stages shrink
    // the half-length (pos = N_LOG2-1-s); inverse stages grow it (pos = s).
    addr_t bf_ext, pos, low_mask, pair_a, pair_b, grp;
    wide_t tw_wide;
    logic  run;

    always_comb begin
        bf_ext   = {1'b0, bf_q};
        pos      = inv_q ? addr_t'(stage_q) : (addr_t'(N_LOG2 - 1) - addr_t'(stage_q));
        low_mask = (addr_t'(1) << pos) - addr_t'(1);
        pair_a   = ((bf_ext & ~low_mask) << 1) | (bf_ext & low_mask);
        pair_b   = pair_a | (addr_t'(1) << pos);
        grp      = bf_ext >> pos;
        // One extra bit so 2^N_LOG2 - 1 - g in inverse stage 0 is exact.
        if (inv_q) begin
            tw_wide = (wide_t'(1) << (addr_t'(N_LOG2) - addr_t'(stage_q)))
                      - wide_t'(1) - wide_t'(grp);
        end else begin
            tw_wide = (wide_t'(1) << stage_q) + wide_t'(grp);
        end
    end

    assign run             = (state_q == RUN);
    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign rd_en_o         = run;
    assign rd_addr_a_o     = run ? pair_a : '0;
    assign rd_addr_b_o     = run ? pair_b : '0;
    assign twiddle_idx_o   = run ? tw_wide[N_LOG2-1:0] : '0;
    assign sel_butterfly_o = inv_q;

    // ---------------- write-back alignment ----------------
    ntt_wb_delay #(
        .DEPTH (PIPE_DEPTH),
        .AW    (N_LOG2)
    ) u_wb_delay (
        .clk        (clk_i),
        .rst        (rst_i),
        .src_valid  (rd_en_o),
        .src_addr_a (rd_addr_a_o),
        .src_addr_b (rd_addr_b_o),
        .dly_valid  (wr_en_o),
        .dly_addr_a (wr_addr_a_o),
        .dly_addr_b (wr_addr_b_o)
    );

endmodule : ntt_sequencer

// File: tb/tb_ntt_sequencer.sv
// Bench for ntt_sequencer: a cycle-indexed reference model checked every
// negative edge, plus directed literal expectations from hand computation.
module tb_ntt_sequencer;

    localparam int L     = 8;
    localparam int D     = 2;
    localparam int H     = 1 << (L - 1);
    localparam int PER   = H + D;
    localparam int TOTAL = L * PER;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic         inverse_i = 1'b0;
    logic         busy_o, done_o, rd_en_o, sel_butterfly_o, wr_en_o;
    logic [L-1:0] rd_addr_a_o, rd_addr_b_o, twiddle_idx_o, wr_addr_a_o, wr_addr_b_o;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int busy_count = 0;
    int done_count = 0;

    // model state: m_k = cycles since the accepted start (-1 = idle)
    int m_k   = -1;
    bit m_inv = 1'b0;
    bit m_sel = 1'b0;

    ntt_sequencer #(.N_LOG2(L), .PIPE_DEPTH(D)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .inverse_i       (inverse_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .rd_en_o         (rd_en_o),
        .rd_addr_a_o     (rd_addr_a_o),
        .rd_addr_b_o     (rd_addr_b_o),
        .twiddle_idx_o   (twiddle_idx_o),
        .sel_butterfly_o (sel_butterfly_o),
        .wr_en_o         (wr_en_o),
        .wr_addr_a_o     (wr_addr_a_o),
        .wr_addr_b_o     (wr_addr_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected read issue for cycle k of a transform, from the stage/group
    // arithmetic: k splits into stage and position within the stage period.
    function automatic void exp_rd(input int k, input bit inv, output bit rd,
                                   output int a, output int b, output int tw);
        int s, r, half, g;
        rd = 1'b0; a = 0; b = 0; tw = 0;
        if (k < 0 || k >= TOTAL) return;
        s = k / PER;
        r = k % PER;
        if (r >= H) return;
        half = inv ? (1 << s) : (1 << (L - 1 - s));
        g    = r / half;
        a    = g * 2 * half + (r % half);
        b    = a + half;
        tw   = inv ? ((1 << (L - s)) - 1 - g) : ((1 << s) + g);
        rd   = 1'b1;
    endfunction

    // model advance
    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                m_k   = -1;
                m_sel = 1'b0;
            end else if ((m_k < 0 || m_k >= TOTAL) && start_i) begin
                m_k   = 0;
                m_inv = inverse_i;
                m_sel = inverse_i;
            end else if (m_k >= 0 && m_k < TOTAL) begin
                m_k++;
            end else begin
                m_k = -1;
            end
        end
    end

    // per-cycle compare against the model
    initial begin
        bit rd, wr;
        int a, b, tw, wa, wb, wt;
        forever begin
            @(negedge clk_i);
            exp_rd(m_k, m_inv, rd, a, b, tw);
            exp_rd(m_k - D, m_inv, wr, wa, wb, wt);
            check("busy", int'(busy_o), int'(m_k >= 0 && m_k < TOTAL));
            check("done", int'(done_o), int'(m_k == TOTAL));
            check("rd_en", int'(rd_en_o), int'(rd));
            check("sel_butterfly", int'(sel_butterfly_o), int'(m_sel));
            check("wr_en", int'(wr_en_o), int'(wr));
            if (rd) begin
                check("rd_addr_a", int'(rd_addr_a_o), a);
                check("rd_addr_b", int'(rd_addr_b_o), b);
                check("twiddle", int'(twiddle_idx_o), tw);
            end
            if (wr) begin
                check("wr_addr_a", int'(wr_addr_a_o), wa);
                check("wr_addr_b", int'(wr_addr_b_o), wb);
            end
            if (wr_en_o) wr_count++;
            if (busy_o) busy_count++;
            if (done_o) done_count++;
        end
    end

    task automatic check_pair(input string nm, input int a, input int b, input int tw);
        check({nm, " rd_en"}, int'(rd_en_o), 1);
        check({nm, " a"}, int'(rd_addr_a_o), a);
        check({nm, " b"}, int'(rd_addr_b_o), b);
        check({nm, " tw"}, int'(twiddle_idx_o), tw);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " busy"}, int'(busy_o), 0);
        check({nm, " done"}, int'(done_o), 0);
        check({nm, " rd_en"}, int'(rd_en_o), 0);
        check({nm, " rd_a"}, int'(rd_addr_a_o), 0);
        check({nm, " rd_b"}, int'(rd_addr_b_o), 0);
        check({nm, " tw"}, int'(twiddle_idx_o), 0);
        check({nm, " sel"}, int'(sel_butterfly_o), 0);
        check({nm, " wr_en"}, int'(wr_en_o), 0);
        check({nm, " wr_a"}, int'(wr_addr_a_o), 0);
        check({nm, " wr_b"}, int'(wr_addr_b_o), 0);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        check({nm, " done within bound"}, int'(seen), 1);
    endtask

    initial begin
        int wr0, busy0, done0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // ---- forward run, start held high throughout, restart in done cycle
        start_i = 1'b1;
        inverse_i = 1'b0;
        #1;
        wr0 = wr_count; busy0 = busy_count; done0 = done_count;
        for (int k = 0; k <= TOTAL; k++) begin
            @(negedge clk_i);
            case (k)
                0:    check_pair("fwd s0 bf0", 0, 128, 1);
                1:    check_pair("fwd s0 bf1", 1, 129, 1);
                2: begin
                    check("fwd wr0 en", int'(wr_en_o), 1);
                    check("fwd wr0 a", int'(wr_addr_a_o), 0);
                    check("fwd wr0 b", int'(wr_addr_b_o), 128);
                end
                127:  check_pair("fwd s0 bf127", 127, 255, 1);
                128:  check("fwd gap0", int'(rd_en_o), 0);
                129:  check("fwd gap1", int'(rd_en_o), 0);
                130:  check_pair("fwd s1 bf0", 0, 64, 2);
                194:  check_pair("fwd s1 bf64", 128, 192, 3);
                300:  inverse_i = 1'b1;
                600:  inverse_i = 1'b0;
                910:  check_pair("fwd s7 bf0", 0, 1, 128);
                1037: check_pair("fwd s7 bf127", 254, 255, 255);
                1039: check("fwd busy last", int'(busy_o), 1);
                TOTAL: begin
                    check("fwd done pulse", int'(done_o), 1);
                    check("fwd busy at done", int'(busy_o), 0);
                    check("fwd sel", int'(sel_butterfly_o), 0);
                    #1;
                    check("fwd write total", wr_count - wr0, 1024);
                    check("fwd busy cycles", busy_count - busy0, TOTAL);
                    check("fwd done pulses", done_count - done0, 1);
                    inverse_i = 1'b1;
                end
                default: ;
            endcase
        end

        // ---- inverse run accepted in the done cycle
        for (int k = 0; k <= TOTAL; k++) begin
            @(negedge clk_i);
            case (k)
                0: begin
                    start_i = 1'b0;
                    check("inv busy", int'(busy_o), 1);
                    check_pair("inv s0 bf0", 0, 1, 255);
                end
                1:    check_pair("inv s0 bf1", 2, 3, 254);
                500:  check("inv sel mid", int'(sel_butterfly_o), 1);
                910: begin
                    check_pair("inv s7 bf0", 0, 128, 1);
                    check("inv sel s7", int'(sel_butterfly_o), 1);
                end
                TOTAL: check("inv done pulse", int'(done_o), 1);
                default: ;
            endcase
        end
        inverse_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // ---- reset in the middle of stage 3
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3 * PER + 10) @(negedge clk_i);
        check("pre-reset rd_en", int'(rd_en_o), 1);
        #2 rst_i = 1'b1;
        #1 check_all_zero("mid reset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1 wr0 = wr_count;
        repeat (10) @(negedge clk_i);
        #1 check("no wr after reset", wr_count - wr0, 0);

        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check_pair("post-reset s0 bf0", 0, 128, 1);
        repeat (PER) @(negedge clk_i);
        check_pair("post-reset s1 bf0", 0, 64, 2);
        wait_done("post-reset");
        repeat (3) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ntt_sequencer
